// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, the NOP encoding and the
// default reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch-stage performance counters (delivered instructions and bubbles).
// Only exists when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_fetch,
  input  logic        count_bubble,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else begin
      if (count_fetch)  perf_fetched <= perf_fetched + 32'd1;
      if (count_bubble) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, drives a variable-latency imem with
// one outstanding request, and feeds F/D. Optional counters with FETCH_PERF_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        pcsrc_d,
  input  logic [31:0] pcbranch_d,
  input  logic        jump_d,
  input  logic [31:0] pcjump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pcplus4_f
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  hold_buf, hold_n;
  logic         kill, kill_n;
  logic         redirect;
  logic [31:0]  target;
  logic         deliver;

  assign redirect  = (jump_d | pcsrc_d) & ~stall_f;
  assign target    = jump_d ? pcjump_d : pcbranch_d;
  assign pcplus4_f = pc + 32'd4;

  // kill marks an outstanding response that belongs to a squashed path; it is
  // dropped on arrival and the fetch is reissued at the (already updated) pc.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    instr_f   = NOP_INSTR;
    deliver   = 1'b0;
    state_n   = state;
    pc_n      = pc;
    kill_n    = kill;
    hold_n    = hold_buf;
    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        state_n  = S_WAIT;
        if (redirect) begin
          imem_addr = target;
          pc_n      = target;
        end
      end
      S_WAIT: begin
        if (!imem_valid) begin
          if (redirect) begin
            pc_n   = target;
            kill_n = 1'b1;
          end
        end else if (kill) begin
          kill_n   = 1'b0;
          imem_req = 1'b1;
          if (redirect) begin
            imem_addr = target;
            pc_n      = target;
          end
        end else if (redirect) begin
          imem_req  = 1'b1;
          imem_addr = target;
          pc_n      = target;
        end else if (stall_f) begin
          hold_n  = imem_rdata;
          state_n = S_HOLD;
        end else begin
          instr_f   = imem_rdata;
          deliver   = 1'b1;
          imem_req  = 1'b1;
          imem_addr = pcplus4_f;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n    = target;
          state_n = S_REQ;
        end else begin
          instr_f = hold_buf;
          if (!stall_f) begin
            deliver = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      default: state_n = S_REQ;
    endcase
    if (deliver) pc_n = pcplus4_f;
    if (reset) begin
      imem_req = 1'b0;
      instr_f  = NOP_INSTR;
      deliver  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      hold_buf <= 32'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      hold_buf <= hold_n;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk          (clk),
    .reset        (reset),
    .count_fetch  (deliver),
    .count_bubble (~stall_f & ~deliver),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );
`endif

endmodule
